// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter sharing one single-port RAM.
// Each access runs IDLE -> ACCESS -> RESP, and every output is registered.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  sel_q, sel_d;
  logic                  we_lat_q, we_lat_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ram_we_q, ram_we_d;
  logic                  pick;

  assign gnt0             = gnt0_q;
  assign gnt1             = gnt1_q;
  assign done0            = done0_q;
  assign done1            = done1_q;
  assign busy             = busy_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign ram_address      = ram_addr_q;
  assign ram_data_in      = ram_din_q;
  assign ram_write_enable = ram_we_q;

  // Next-state and registered-output logic for the three-step access sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_lat_d     = we_lat_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    done0_d      = done0_q;
    done1_d      = done1_q;
    busy_d       = busy_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = ram_we_q;
    pick         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ram_we_d = 1'b0;
        busy_d   = 1'b0;
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes next.
          pick       = (req0 && req1) ? ~last_grant_q : req1;
          sel_d      = pick;
          we_lat_d   = pick ? we1 : we0;
          ram_addr_d = pick ? addr1 : addr0;
          ram_din_d  = pick ? wdata1 : wdata0;
          ram_we_d   = pick ? we1 : we0;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          busy_d     = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_lat_q) begin
          if (sel_q) rdata1_d = ram_data_out;
          else       rdata0_d = ram_data_out;
        end
        ram_we_d     = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = ~sel_q;
        done1_d      = sel_q;
        last_grant_d = sel_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_lat_q     <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_lat_q     <= we_lat_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-level reference with an attached RAM model.
module tb_ram_port_arbiter;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, done0, done1, busy, ram_write_enable;
  logic [7:0] rdata0, rdata1, ram_data_in, ram_data_out;
  logic [3:0] ram_address;

  int n_checks = 0;
  int n_fail   = 0;

  // Physical RAM: combinational read, synchronous write.
  logic [7:0] ram [16];
  assign ram_data_out = ram[ram_address];
  always @(posedge clk) if (ram_write_enable) ram[ram_address] <= ram_data_in;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  // Reference model: an accepted access occupies edges g_edge..g_edge+2.
  txn_t       q0[$], q1[$];
  logic [7:0] ref_mem [16];
  int         k = 0;
  int         g_edge = -100;
  bit         g_port, g_we, last;
  logic [3:0] g_addr, exp_addr;
  logic [7:0] g_data, exp_din, exp_rd0, exp_rd1;
  int         glog[$];
  int         gcyc[$];

  function automatic txn_t mk(logic w, logic [3:0] a, logic [7:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic drive_ports();
    req0 = (q0.size() != 0);
    req1 = (q1.size() != 0);
    if (req0) {we0, addr0, wdata0} = q0[0];
    else {we0, addr0, wdata0} = 13'($urandom);
    if (req1) {we1, addr1, wdata1} = q1[0];
    else {we1, addr1, wdata1} = 13'($urandom);
  endtask

  task automatic model_reset();
    g_edge = -100; last = 1'b1;
    exp_addr = '0; exp_din = '0; exp_rd0 = '0; exp_rd1 = '0;
    q0.delete(); q1.delete();
    drive_ports();
  endtask

  task automatic step();
    logic [33:0] exp_v, act_v;
    bit eg, ed;
    txn_t t;
    if (k == g_edge + 1) begin
      if (g_we) ref_mem[g_addr] = g_data;
      else if (g_port) exp_rd1 = ref_mem[g_addr];
      else exp_rd0 = ref_mem[g_addr];
    end else if (k >= g_edge + 3 && (req0 || req1)) begin
      g_port = (req0 && req1) ? !last : req1;
      t = g_port ? q1[0] : q0[0];
      g_edge = k; g_we = t.we; g_addr = t.addr; g_data = t.data;
      last = g_port; exp_addr = t.addr; exp_din = t.data;
    end
    @(posedge clk); #1;
    eg = (k == g_edge);
    ed = (k == g_edge + 1);
    exp_v = {eg & !g_port, eg & g_port, ed & !g_port, ed & g_port, eg | ed, eg & g_we,
             exp_addr, exp_din, exp_rd0, exp_rd1};
    act_v = {gnt0, gnt1, done0, done1, busy, ram_write_enable,
             ram_address, ram_data_in, rdata0, rdata1};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs edge=%0d got=%h expected=%h", k, act_v, exp_v);
    end
    k++;
    if (gnt0) begin glog.push_back(0); gcyc.push_back(k); end
    if (gnt1) begin glog.push_back(1); gcyc.push_back(k); end
    if (gnt0 && q0.size() > 0) t = q0.pop_front();
    if (gnt1 && q1.size() > 0) t = q1.pop_front();
    drive_ports();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || k < g_edge + 3) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL idle_timeout got=%0d cycles required<%0d", n, budget);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({gnt0, gnt1, done0, done1, busy, ram_write_enable, ram_address, ram_data_in, rdata0, rdata1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got nonzero outputs required all zero");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) step();
  endtask

  task automatic test_mid_reset();
    q0.push_back(mk(1'b1, 4'h5, 8'h77));
    drive_ports();
    glog.delete();
    for (int i = 0; i < 10 && glog.size() == 0; i++) step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_write_enable !== 1'b0 || gnt0 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_we got we=%b gnt0=%b required 0 0", ram_write_enable, gnt0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    q0.push_back(mk(1'b0, 4'h5, 8'h00));
    drive_ports();
    run_until_idle(20);
    n_checks++;
    if (rdata0 !== 8'h00) begin
      n_fail++;
      $display("FAIL abandoned_write got=%h required=00", rdata0);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    q0.push_back(mk(1'b1, 4'h1, 8'($urandom)));
    q1.push_back(mk(1'b1, 4'h3, 8'($urandom)));
    drive_ports();
    glog.delete(); gcyc.delete();
    run_until_idle(20);
    n_checks++;
    if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1 || gcyc[1] - gcyc[0] != 3) begin
      n_fail++;
      $display("FAIL tie_order got %0d grants required port0 then port1 three cycles apart", glog.size());
    end
  endtask

  task automatic test_write_read();
    q0.push_back(mk(1'b1, 4'h2, 8'hAA));
    drive_ports();
    run_until_idle(20);
    q0.push_back(mk(1'b0, 4'h2, 8'h00));
    drive_ports();
    run_until_idle(20);
    n_checks++;
    if (rdata0 !== 8'hAA) begin
      n_fail++;
      $display("FAIL write_read got=%h required=AA", rdata0);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'($urandom), 4'($urandom_range(1, 14)), 8'($urandom)));
      q1.push_back(mk(1'($urandom), 4'($urandom_range(1, 14)), 8'($urandom)));
    end
    drive_ports();
    glog.delete(); gcyc.delete();
    run_until_idle(40);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (glog.size() != 8 || glog[i] != (i % 2) || (i > 0 && gcyc[i] - gcyc[i-1] != 3)) begin
        n_fail++;
        $display("FAIL fairness_order grant %0d got port %0d required port %0d", i,
                 (i < glog.size()) ? glog[i] : -1, i % 2);
      end
    end
  endtask

  task automatic test_cross_port();
    logic [7:0] r1;
    q1.push_back(mk(1'b1, 4'hF, 8'h5C));
    drive_ports();
    run_until_idle(20);
    r1 = exp_rd1;
    q0.push_back(mk(1'b0, 4'hF, 8'h00));
    drive_ports();
    run_until_idle(20);
    n_checks++;
    if (rdata0 !== 8'h5C || rdata1 !== r1) begin
      n_fail++;
      $display("FAIL cross_port got rdata0=%h rdata1=%h required 5C %h", rdata0, rdata1, r1);
    end
  endtask

  task automatic test_read_hold();
    q1.push_back(mk(1'b0, 4'h0, 8'h00));
    drive_ports();
    glog.delete();
    for (int i = 0; i < 10 && glog.size() == 0; i++) step();
    q0.push_back(mk(1'b1, 4'h7, 8'h3C));
    drive_ports();
    run_until_idle(20);
    n_checks++;
    if (glog.size() != 2 || glog[1] != 0 || rdata1 !== 8'h00) begin
      n_fail++;
      $display("FAIL busy_ignore got grants=%0d rdata1=%h required 2 grants rdata1=00", glog.size(), rdata1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 2)
        q0.push_back(mk(1'($urandom), 4'($urandom), 8'($urandom)));
      if ($urandom_range(0, 2) == 0 && q1.size() < 2)
        q1.push_back(mk(1'($urandom), 4'($urandom), 8'($urandom)));
      drive_ports();
      step();
    end
    run_until_idle(60);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_mid_reset();
    test_simultaneous();
    test_write_read();
    test_fairness();
    test_cross_port();
    test_read_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares one single-port 16x8 RAM between two requesters (port 0, port 1).
- Sits between the two requesters and the RAM's address / data_in / write_enable / data_out pins.
- Accepts one request at a time, drives a single write or read access, and returns read data with a one-cycle done pulse.
- Fixed 3-cycle access sequence (IDLE, ACCESS, RESP) guarantees write_enable is never asserted while the address or data is changing.

Parameters:
- ADDR_WIDTH, 4, RAM address width (16 words)
- DATA_WIDTH, 8, RAM data width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0 / req1  input  1  access request from port 0 / 1
- we0 / we1  input  1  1 = write, 0 = read; valid while reqN=1
- addr0 / addr1  input  ADDR_WIDTH  access address; valid while reqN=1
- wdata0 / wdata1  input  DATA_WIDTH  write data; valid while reqN=1
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted and its fields latched
- done0 / done1  output  1  one-cycle pulse: access complete
- rdata0 / rdata1  output  DATA_WIDTH  read data; valid while doneN=1, then held
- busy  output  1  high in ACCESS and RESP
- ram_address  output  ADDR_WIDTH  to RAM address
- ram_data_in  output  DATA_WIDTH  to RAM data_in
- ram_write_enable  output  1  to RAM write_enable
- ram_data_out  input  DATA_WIDTH  from RAM data_out; combinational read

Behaviour:
- Reset:
  - Every output register clears to 0: gnt*, done*, rdata*, busy, ram_address, ram_data_in, ram_write_enable.
  - State goes to IDLE; last_grant goes to 1, so port 0 wins the first tie.
  - Reset is asynchronous. ram_write_enable drops immediately, even in mid-access. An in-flight access is abandoned and no done pulse is issued.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- IDLE:
  - If any reqN=1 at a clock edge, select a winner.
    - Only one request: grant that port.
    - Both requesting: grant the port that is NOT last_grant.
  - At that edge, latch the winner's we, addr and wdata.
  - Load ram_address and ram_data_in from the latched fields.
  - Set gntN=1 and go to ACCESS.
  - If no request, stay in IDLE; ram_write_enable=0 and the address/data outputs hold.
- ACCESS (1 cycle):
  - gntN=1 and busy=1.
  - ram_write_enable equals the latched we.
  - ram_address and ram_data_in are stable for the whole cycle.
  - At the closing edge:
    - If the access is a read, capture ram_data_out into rdataN.
    - Clear ram_write_enable and gntN.
    - Set doneN=1, set last_grant to the winner, and go to RESP.
- RESP (1 cycle):
  - doneN=1, busy=1, ram_write_enable=0; address and data still held.
  - At the closing edge, clear doneN and go to IDLE.
- Latency and throughput:
  - A request sampled at edge E0 produces gnt high in E0→E1, the RAM access in E0→E1, and done in E1→E2.
  - Maximum throughput is one access per 3 cycles.
- Requester rule:
  - Hold reqN and its fields stable until gntN is seen.
  - Deassert req in the gnt cycle for a single access.
  - A req still high at the next IDLE edge counts as a new request.
- Writes: rdataN is unchanged.
- Read data: rdataN holds its value until that port's next read completes.
- Starvation: with both ports requesting continuously, grants alternate 0,1,0,1… and neither port waits more than one access.
- Request while busy: it is ignored until IDLE. It is not queued; the held req is simply sampled again.
- Address wrap: none is needed; the full 2^ADDR_WIDTH range is passed through.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release, no req → all outputs 0, busy=0; assert rst_n=0 in mid-ACCESS of a write → ram_write_enable drops without waiting for clk, no done pulse.
- Single write then read on port 0:
  - req0, we0=1, addr0=4'h2, wdata0=8'hAA → gnt0 one cycle later; ram_write_enable=1 for exactly 1 cycle with ram_address=2, ram_data_in=AA; done0 the next cycle.
  - Then read addr0=2 → done0 with rdata0=8'hAA.
- Simultaneous requests from reset: req0 and req1 both high with writes to 1 and 3 → port 0 granted first, then port 1. Grants are 3 cycles apart; gnt1 never overlaps gnt0.
- Fairness under load: both ports hold req for 12 cycles → grant order 0,1,0,1; each done in its own cycle; busy low for exactly 1 IDLE cycle between accesses.
- Cross-port data: port 1 writes 8'h5C to addr 4'hF (wrap-edge address), then port 0 reads 4'hF → rdata0=8'h5C, rdata1 unchanged.
- Read hold and busy ignore:
  - Port 1 reads addr 0 (contains 8'h00).
  - During its ACCESS, port 0 raises req → not granted until IDLE.
  - rdata1=8'h00 holds through port 0's subsequent write.
